// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared definitions for the SOPC unified-memory arbiter: FSM states,
// counter width and master-count limits.
package sopc_mem_arbiter_pkg;

   localparam int unsigned MAX_MASTERS = 8;
   localparam int unsigned CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Index width that stays legal for a single master.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sopc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after the
// last-served index, wrapping modulo NUM_M.
module sopc_rr_arbiter
   import sopc_mem_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_M = 2,
   localparam int unsigned IDX_W = idx_width(NUM_M)
) (
   input  logic [NUM_M-1:0] req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [NUM_M-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   int unsigned pos;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      pos     = 0;
      for (int unsigned k = 1; k <= NUM_M; k++) begin
         pos = 32'(last_i) + k;
         if (pos >= NUM_M) pos = pos - NUM_M;
         if (!valid_o && req_i[pos[IDX_W-1:0]]) begin
            valid_o                 = 1'b1;
            idx_o                   = pos[IDX_W-1:0];
            grant_o[pos[IDX_W-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Shares one single-port memory among NUM_M masters: round-robin grant,
// programmable wait states, registered read data and one-cycle ack pulse.
module sopc_mem_arbiter
   import sopc_mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_M       = 2,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_M-1:0]              m_req,
   input  logic [NUM_M-1:0]              m_we,
   input  logic [NUM_M*ADDR_W-1:0]       m_addr,
   input  logic [NUM_M*DATA_W-1:0]       m_wdata,
   input  logic [NUM_M*(DATA_W/8)-1:0]   m_sel,
   output logic [DATA_W-1:0]             m_rdata,
   output logic [NUM_M-1:0]              m_ack,
   output logic [NUM_M-1:0]              m_stall,
   output logic                          s_ce,
   output logic                          s_we,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   output logic [DATA_W/8-1:0]           s_sel,
   input  logic [DATA_W-1:0]             s_rdata
);

   localparam int unsigned SEL_W = DATA_W / 8;
   localparam int unsigned IDX_W = idx_width(NUM_M);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [IDX_W-1:0]   last_q,  last_d;
   logic [NUM_M-1:0]   gnt_q,   gnt_d;
   logic               we_q,    we_d;
   logic [ADDR_W-1:0]  addr_q,  addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [SEL_W-1:0]   sel_q,   sel_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [NUM_M-1:0]   ack_q,   ack_d;

   logic [NUM_M-1:0]   arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;

   sopc_rr_arbiter #(.NUM_M(NUM_M)) u_rr (
      .req_i   (m_req),
      .last_i  (last_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= IDX_W'(NUM_M - 1);
         gnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
      end
   end

   // Master inputs are only looked at in IDLE; after the grant the latched
   // copies drive the memory, so a master dropping req cannot cancel an access.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      sel_d   = sel_q;
      rdata_d = rdata_q;
      ack_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               gnt_d   = arb_grant;
               last_d  = arb_idx;
               we_d    = m_we[arb_idx];
               addr_d  = m_addr[arb_idx*ADDR_W +: ADDR_W];
               wdata_d = m_wdata[arb_idx*DATA_W +: DATA_W];
               sel_d   = m_sel[arb_idx*SEL_W +: SEL_W];
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (!we_q) rdata_d = s_rdata;
               ack_d   = gnt_q;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign s_ce    = (state_q == ST_ACCESS);
   assign s_we    = s_ce & we_q;
   assign s_addr  = addr_q;
   assign s_wdata = wdata_q;
   assign s_sel   = sel_q;
   assign m_rdata = rdata_q;
   assign m_ack   = ack_q;
   assign m_stall = m_req & ~ack_q;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Randomized scoreboard bench for sopc_mem_arbiter with a transaction-level
// reference model and a small byte-addressable memory slave.
module tb_sopc_mem_arbiter;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int W  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NM-1:0]    m_req, m_we, m_ack, m_stall;
   logic [NM*AW-1:0] m_addr;
   logic [NM*DW-1:0] m_wdata;
   logic [NM*SW-1:0] m_sel;
   logic [DW-1:0]    m_rdata, s_wdata, s_rdata;
   logic             s_ce, s_we;
   logic [AW-1:0]    s_addr;
   logic [SW-1:0]    s_sel;

   logic [DW-1:0] mem     [16];
   logic [DW-1:0] ref_mem [16];

   assign s_rdata = s_ce ? mem[s_addr[5:2]] : '0;

   sopc_mem_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_sel   (m_sel),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .m_stall (m_stall),
      .s_ce    (s_ce),
      .s_we    (s_we),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_sel   (s_sel),
      .s_rdata (s_rdata)
   );

   typedef struct {
      int            idx;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] sel;
      logic [DW-1:0] rdata;
      int            first;
      int            lastacc;
      int            ack_edge;
   } txn_t;

   txn_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   edge_cnt = 0;

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_1111);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h edge=%0d", name, act, exp, edge_cnt);
      end
   endtask

   // Memory slave: combinational read, byte-masked write on the clock edge.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (s_ce && s_we)
            for (int b = 0; b < SW; b++)
               if (s_sel[b]) mem[s_addr[5:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
      end
   end

   // Reference model: whole transactions, one at a time, W+3 cycles each.
   initial begin
      int            last, free_at, g;
      logic [DW-1:0] last_rd;
      txn_t          t;
      last = NM - 1; free_at = 0; last_rd = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (rst) begin
            q.delete();
            last    = NM - 1;
            free_at = edge_cnt + 1;
            last_rd = '0;
         end else if (edge_cnt >= free_at && m_req != '0) begin
            g = -1;
            for (int k = 1; k <= NM; k++) begin
               int j;
               j = (last + k) % NM;
               if (g < 0 && m_req[j]) g = j;
            end
            t.idx   = g;
            t.we    = m_we[g];
            t.addr  = m_addr[g*AW +: AW];
            t.wdata = m_wdata[g*DW +: DW];
            t.sel   = m_sel[g*SW +: SW];
            if (t.we) begin
               for (int b = 0; b < SW; b++)
                  if (t.sel[b]) ref_mem[t.addr[5:2]][b*8 +: 8] = t.wdata[b*8 +: 8];
               t.rdata = last_rd;
            end else begin
               t.rdata = ref_mem[t.addr[5:2]];
               last_rd = t.rdata;
            end
            t.first    = edge_cnt + 1;
            t.lastacc  = edge_cnt + W + 1;
            t.ack_edge = edge_cnt + W + 2;
            free_at    = edge_cnt + W + 3;
            last       = g;
            q.push_back(t);
         end
         edge_cnt++;
      end
   end

   // Monitor: compares the memory side and the ack/stall side every cycle.
   initial begin
      logic [NM-1:0] exp_ack, one;
      bit            due, active;
      txn_t          t;
      forever begin
         @(negedge clk);
         due     = (q.size() > 0) && (q[0].ack_edge == edge_cnt);
         exp_ack = '0;
         if (due) exp_ack[q[0].idx] = 1'b1;
         check("m_stall", 64'(m_stall), 64'(m_req & ~exp_ack));
         active = (q.size() > 0) && (edge_cnt >= q[0].first) && (edge_cnt <= q[0].lastacc);
         check("s_ce", 64'(s_ce), 64'(active));
         if (active) begin
            check("s_we",   64'(s_we),   64'(q[0].we));
            check("s_addr", 64'(s_addr), 64'(q[0].addr));
            check("s_sel",  64'(s_sel),  64'(q[0].sel));
            if (q[0].we) check("s_wdata", 64'(s_wdata), 64'(q[0].wdata));
         end
         if (m_ack != '0 || due) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_ack actual=%b required=%b edge=%0d", m_ack, {NM{1'b0}}, edge_cnt);
            end else begin
               t   = q.pop_front();
               one = '0;
               one[t.idx] = 1'b1;
               check("ack_vec",  64'(m_ack),    64'(one));
               check("ack_time", 64'(edge_cnt), 64'(t.ack_edge));
               check("m_rdata",  64'(m_rdata),  64'(t.rdata));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   logic [NM-1:0] busy;
   int            gap   [NM];
   int            waitc [NM];

   task automatic issue(input int k);
      m_req[k]             = 1'b1;
      m_we[k]              = 1'($urandom_range(0, 1));
      m_addr[k*AW +: AW]   = $urandom() & 32'hFFFF_FFFC;
      m_wdata[k*DW +: DW]  = $urandom();
      m_sel[k*SW +: SW]    = 4'($urandom_range(1, 15));
      busy[k]  = 1'b1;
      waitc[k] = 0;
   endtask

   // One cycle of the master drivers: release on ack, else maybe issue.
   task automatic step(input logic [NM-1:0] new_ok, input bit zero_gap);
      logic [NM-1:0] got;
      @(negedge clk);
      got = m_ack;
      @(posedge clk);
      #1;
      for (int k = 0; k < NM; k++) begin
         if (busy[k]) begin
            if (got[k]) begin
               m_req[k] = 1'b0;
               busy[k]  = 1'b0;
               gap[k]   = zero_gap ? 0 : int'($urandom_range(0, 3));
            end else begin
               waitc[k]++;
               if (waitc[k] > 100) begin
                  checks++;
                  failures++;
                  $display("FAIL req_timeout master=%0d actual=no_ack required=ack", k);
                  m_req[k] = 1'b0;
                  busy[k]  = 1'b0;
               end
            end
         end else if (new_ok[k]) begin
            if (gap[k] == 0) issue(k);
            else gap[k]--;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (busy != '0 && n < 400) begin
         step('0, 1'b0);
         n++;
      end
      repeat (W + 4) step('0, 1'b0);
      for (int k = 0; k < NM; k++) gap[k] = 0;
   endtask

   initial begin
      m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_sel = '0; busy = '0;
      for (int k = 0; k < NM; k++) begin gap[k] = 0; waitc[k] = 0; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_m_ack",   64'(m_ack),   64'(0));
      check("rst_m_rdata", 64'(m_rdata), 64'(0));
      check("rst_s_ce",    64'(s_ce),    64'(0));
      check("rst_s_we",    64'(s_we),    64'(0));
      check("rst_s_addr",  64'(s_addr),  64'(0));
      check("rst_s_wdata", 64'(s_wdata), 64'(0));
      check("rst_s_sel",   64'(s_sel),   64'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      repeat (600) step('1, 1'b0);
      drain();
      repeat (80) step('1, 1'b1);
      drain();

      // Requester drops req during its ACCESS phase.
      step(3'b010, 1'b0);
      step('0, 1'b0);
      m_req[1] = 1'b0;
      busy[1]  = 1'b0;
      repeat (W + 6) step('0, 1'b0);

      // Reset during the second ACCESS cycle, then all three request.
      step(3'b110, 1'b0);
      step('0, 1'b0);
      step('0, 1'b0);
      rst = 1'b1;
      step(3'b001, 1'b0);
      rst = 1'b0;
      drain();

      check("scoreboard_empty", 64'(q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
